// File: rtl/blub_pkg.sv
// Shared FP format definitions for the operand lane datapath.
package blub_pkg;

  typedef enum logic [1:0] {
    FP64 = 2'd0,
    FP32 = 2'd1,
    FP16 = 2'd2,
    FP8  = 2'd3
  } fmt_e;

  localparam int unsigned MIN_FP_WIDTH = 8;

  function automatic int unsigned fp_width(input fmt_e fmt);
    case (fmt)
      FP64:    return 64;
      FP32:    return 32;
      FP16:    return 16;
      FP8:     return 8;
      default: return 64;
    endcase
  endfunction

  function automatic int unsigned num_lanes(input fmt_e fmt, input int unsigned width);
    return width / fp_width(fmt);
  endfunction

endpackage

// File: rtl/blub_lane_extract.sv
// Combinational lane picker: right-aligns lane N of an operand and zero-fills the rest.
module blub_lane_extract
  import blub_pkg::*;
#(
  parameter int unsigned WIDTH = 64
) (
  input  logic [WIDTH-1:0]                      operand_i,
  input  fmt_e                                  fmt_i,
  input  logic [$clog2(WIDTH/MIN_FP_WIDTH)-1:0] lane_idx_i,
  output logic [WIDTH-1:0]                      lane_o
);

  localparam int unsigned SH_W = $clog2(WIDTH) + 1;

  logic [SH_W-1:0]  w_fpw;
  logic [SH_W-1:0]  w_shamt;
  logic [WIDTH-1:0] w_mask;

  always_comb begin
    w_fpw   = SH_W'(fp_width(fmt_i));
    w_shamt = SH_W'(lane_idx_i) * w_fpw;
    // A full-width lane shifts the 1 out entirely, so the subtraction yields all ones.
    w_mask  = (WIDTH'(1) << w_fpw) - WIDTH'(1);
    lane_o  = (operand_i >> w_shamt) & w_mask;
  end

endmodule

// File: rtl/blub_lane_serializer.sv
// Captures a packed multi-operand word and emits it one right-aligned lane per handshake.
module blub_lane_serializer
  import blub_pkg::*;
#(
  parameter int unsigned NUM_OPERANDS = 3,
  parameter int unsigned WIDTH        = 64
) (
  input  logic                                  clk_i,
  input  logic                                  rst_ni,
  input  logic                                  in_valid_i,
  output logic                                  in_ready_o,
  input  logic [NUM_OPERANDS*WIDTH-1:0]         operands_i,
  input  fmt_e                                  src_fmt_i,
  output logic                                  out_valid_o,
  input  logic                                  out_ready_i,
  output logic [NUM_OPERANDS*WIDTH-1:0]         lane_operands_o,
  output logic [$clog2(WIDTH/MIN_FP_WIDTH)-1:0] lane_idx_o,
  output logic                                  last_o
);

  localparam int unsigned LIDX_W = $clog2(WIDTH / MIN_FP_WIDTH);

  typedef enum logic {
    S_IDLE,
    S_EMIT
  } state_e;

  state_e                          r_state;
  logic [NUM_OPERANDS*WIDTH-1:0]   r_ops;
  fmt_e                            r_fmt;
  logic [LIDX_W-1:0]               r_cnt;

  logic                            w_emit;
  logic                            w_cnt_last;
  logic [LIDX_W-1:0]               w_last_idx;

  always_comb begin
    w_emit      = (r_state == S_EMIT);
    w_last_idx  = LIDX_W'(num_lanes(r_fmt, WIDTH) - 1);
    w_cnt_last  = (r_cnt == w_last_idx);
    // Gated by EMIT so the reset/idle view never flags last even when r_fmt is FP64.
    last_o      = w_emit && w_cnt_last;
    out_valid_o = w_emit;
    in_ready_o  = !w_emit || (w_cnt_last && out_ready_i);
    lane_idx_o  = r_cnt;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state <= S_IDLE;
      r_ops   <= '0;
      r_fmt   <= FP64;
      r_cnt   <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (in_valid_i) begin
            r_ops   <= operands_i;
            r_fmt   <= src_fmt_i;
            r_cnt   <= '0;
            r_state <= S_EMIT;
          end
        end
        S_EMIT: begin
          if (out_ready_i) begin
            if (!w_cnt_last) begin
              r_cnt <= r_cnt + LIDX_W'(1);
            end else if (in_valid_i) begin
              r_ops <= operands_i;
              r_fmt <= src_fmt_i;
              r_cnt <= '0;
            end else begin
              r_state <= S_IDLE;
            end
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  for (genvar g = 0; g < NUM_OPERANDS; g++) begin : g_lane
    blub_lane_extract #(
      .WIDTH(WIDTH)
    ) u_extract (
      .operand_i (r_ops[g*WIDTH +: WIDTH]),
      .fmt_i     (r_fmt),
      .lane_idx_i(r_cnt),
      .lane_o    (lane_operands_o[g*WIDTH +: WIDTH])
    );
  end

endmodule

// File: tb/tb_blub_lane_serializer.sv
// Directed bench for blub_lane_serializer: drives and checks on the falling clock edge.
module tb_blub_lane_serializer;
  import blub_pkg::*;

  localparam int unsigned NOPS = 3;
  localparam int unsigned W    = 64;
  localparam int unsigned LW   = 3;

  logic              clk;
  logic              rst_n;
  logic              in_valid;
  logic              in_ready;
  logic [NOPS*W-1:0] ops;
  fmt_e              fmt;
  logic              out_valid;
  logic              out_ready;
  logic [NOPS*W-1:0] lane_ops;
  logic [LW-1:0]     lane_idx;
  logic              last;

  int checks;
  int failures;

  blub_lane_serializer #(
    .NUM_OPERANDS(NOPS),
    .WIDTH       (W)
  ) dut (
    .clk_i          (clk),
    .rst_ni         (rst_n),
    .in_valid_i     (in_valid),
    .in_ready_o     (in_ready),
    .operands_i     (ops),
    .src_fmt_i      (fmt),
    .out_valid_o    (out_valid),
    .out_ready_i    (out_ready),
    .lane_operands_o(lane_ops),
    .lane_idx_o     (lane_idx),
    .last_o         (last)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  task automatic test_reset();
    rst_n = 1'b0; in_valid = 1'b0; ops = '0; fmt = FP64; out_ready = 1'b0;
    #1;
    checks++;
    if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_valid: got %b want 0", out_valid); end
    checks++;
    if (in_ready !== 1'b1) begin failures++; $display("FAIL reset_ready: got %b want 1", in_ready); end
    checks++;
    if (lane_ops !== '0 || lane_idx !== '0 || last !== 1'b0) begin
      failures++; $display("FAIL reset_outs: lane=%h idx=%0d last=%b want 0/0/0", lane_ops, lane_idx, last);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || last !== 1'b0) begin
      failures++; $display("FAIL post_reset_idle: valid=%b ready=%b last=%b want 0/1/0", out_valid, in_ready, last);
    end
  endtask

  task automatic test_fp32_basic();
    @(negedge clk);
    in_valid = 1'b1; fmt = FP32; out_ready = 1'b1;
    ops = {64'h0, 64'hFFFF_FFFF_FFFF_FFFF, 64'h1111_2222_3333_4444};
    checks++;
    if (in_ready !== 1'b1) begin failures++; $display("FAIL fp32_in_ready: got %b want 1", in_ready); end
    @(negedge clk);
    in_valid = 1'b0; ops = {3{64'hDEAD_BEEF_CAFE_F00D}};
    checks++;
    if (out_valid !== 1'b1 || lane_idx !== 3'd0 || last !== 1'b0 ||
        lane_ops !== {64'h0, 64'h0000_0000_FFFF_FFFF, 64'h0000_0000_3333_4444}) begin
      failures++; $display("FAIL fp32_lane0: v=%b idx=%0d last=%b lane=%h", out_valid, lane_idx, last, lane_ops);
    end
    checks++;
    if (in_ready !== 1'b0) begin failures++; $display("FAIL fp32_busy_ready: got %b want 0", in_ready); end
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b1 || lane_idx !== 3'd1 || last !== 1'b1 || in_ready !== 1'b1 ||
        lane_ops !== {64'h0, 64'h0000_0000_FFFF_FFFF, 64'h0000_0000_1111_2222}) begin
      failures++; $display("FAIL fp32_lane1: v=%b idx=%0d last=%b rdy=%b lane=%h", out_valid, lane_idx, last, in_ready, lane_ops);
    end
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b0) begin failures++; $display("FAIL fp32_done: valid=%b want 0", out_valid); end
  endtask

  task automatic test_fp8_order();
    logic [7:0] exp_b;
    @(negedge clk);
    in_valid = 1'b1; fmt = FP8; out_ready = 1'b1;
    ops = {128'h0, 64'h0807_0605_0403_0201};
    @(negedge clk);
    in_valid = 1'b0;
    for (int unsigned i = 0; i < 8; i++) begin
      exp_b = 8'(i + 1);
      checks++;
      if (out_valid !== 1'b1 || lane_idx !== 3'(i) || last !== (i == 7) ||
          lane_ops !== {128'h0, 56'h0, exp_b}) begin
        failures++; $display("FAIL fp8_lane%0d: v=%b idx=%0d last=%b lane=%h want %h", i, out_valid, lane_idx, last, lane_ops[63:0], exp_b);
      end
      @(negedge clk);
    end
    checks++;
    if (out_valid !== 1'b0) begin failures++; $display("FAIL fp8_done: valid=%b want 0", out_valid); end
  endtask

  task automatic test_backpressure();
    @(negedge clk);
    in_valid = 1'b1; fmt = FP16; out_ready = 1'b1;
    ops = {128'h0, 64'h4444_3333_2222_1111};
    @(negedge clk);
    in_valid = 1'b0;
    checks++;
    if (lane_idx !== 3'd0 || lane_ops[63:0] !== 64'h1111) begin
      failures++; $display("FAIL bp_lane0: idx=%0d lane=%h want 0/1111", lane_idx, lane_ops[63:0]);
    end
    @(negedge clk);
    out_ready = 1'b0;
    checks++;
    if (in_ready !== 1'b0) begin failures++; $display("FAIL bp_in_ready: got %b want 0", in_ready); end
    for (int unsigned i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++;
      if (out_valid !== 1'b1 || lane_idx !== 3'd1 || last !== 1'b0 || lane_ops !== {128'h0, 64'h2222}) begin
        failures++; $display("FAIL bp_hold%0d: v=%b idx=%0d last=%b lane=%h want 1/1/0/2222", i, out_valid, lane_idx, last, lane_ops[63:0]);
      end
    end
    out_ready = 1'b1;
    @(negedge clk);
    checks++;
    if (lane_idx !== 3'd2 || lane_ops[63:0] !== 64'h3333 || last !== 1'b0) begin
      failures++; $display("FAIL bp_lane2: idx=%0d lane=%h last=%b want 2/3333/0", lane_idx, lane_ops[63:0], last);
    end
    @(negedge clk);
    checks++;
    if (lane_idx !== 3'd3 || lane_ops[63:0] !== 64'h4444 || last !== 1'b1) begin
      failures++; $display("FAIL bp_lane3: idx=%0d lane=%h last=%b want 3/4444/1", lane_idx, lane_ops[63:0], last);
    end
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b0) begin failures++; $display("FAIL bp_done: valid=%b want 0", out_valid); end
  endtask

  task automatic test_back_to_back();
    @(negedge clk);
    in_valid = 1'b1; fmt = FP64; out_ready = 1'b1;
    ops = {64'hA3A3_A3A3_A3A3_A3A3, 64'hA2A2_A2A2_A2A2_A2A2, 64'hA1A1_A1A1_A1A1_A1A1};
    @(negedge clk);
    ops = {64'hB3B3_B3B3_B3B3_B3B3, 64'hB2B2_B2B2_B2B2_B2B2, 64'hB1B1_B1B1_B1B1_B1B1};
    checks++;
    if (out_valid !== 1'b1 || last !== 1'b1 || in_ready !== 1'b1 || lane_idx !== 3'd0 ||
        lane_ops !== {64'hA3A3_A3A3_A3A3_A3A3, 64'hA2A2_A2A2_A2A2_A2A2, 64'hA1A1_A1A1_A1A1_A1A1}) begin
      failures++; $display("FAIL b2b_first: v=%b last=%b rdy=%b idx=%0d lane=%h", out_valid, last, in_ready, lane_idx, lane_ops);
    end
    @(negedge clk);
    in_valid = 1'b0;
    checks++;
    if (out_valid !== 1'b1 || last !== 1'b1 || lane_idx !== 3'd0 ||
        lane_ops !== {64'hB3B3_B3B3_B3B3_B3B3, 64'hB2B2_B2B2_B2B2_B2B2, 64'hB1B1_B1B1_B1B1_B1B1}) begin
      failures++; $display("FAIL b2b_second: v=%b last=%b idx=%0d lane=%h", out_valid, last, lane_idx, lane_ops);
    end
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b0) begin failures++; $display("FAIL b2b_done: valid=%b want 0", out_valid); end
  endtask

  task automatic test_mid_reset();
    @(negedge clk);
    in_valid = 1'b1; fmt = FP8; out_ready = 1'b1;
    ops = {128'h0, 64'h0807_0605_0403_0201};
    @(negedge clk);
    in_valid = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if (lane_idx !== 3'd3 || lane_ops[63:0] !== 64'h04) begin
      failures++; $display("FAIL rst_pre_lane3: idx=%0d lane=%h want 3/04", lane_idx, lane_ops[63:0]);
    end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || lane_idx !== '0 || lane_ops !== '0 || last !== 1'b0) begin
      failures++; $display("FAIL rst_async: v=%b rdy=%b idx=%0d last=%b lane=%h want 0/1/0/0/0", out_valid, in_ready, lane_idx, last, lane_ops);
    end
    @(negedge clk);
    rst_n = 1'b1;
    in_valid = 1'b1;
    ops = {128'h0, 64'h1817_1615_1413_1211};
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      failures++; $display("FAIL rst_release: rdy=%b v=%b want 1/0", in_ready, out_valid);
    end
    @(negedge clk);
    in_valid = 1'b0;
    checks++;
    if (out_valid !== 1'b1 || lane_idx !== 3'd0 || lane_ops[63:0] !== 64'h11) begin
      failures++; $display("FAIL rst_restart_lane0: v=%b idx=%0d lane=%h want 1/0/11", out_valid, lane_idx, lane_ops[63:0]);
    end
    @(negedge clk);
    checks++;
    if (lane_idx !== 3'd1 || lane_ops[63:0] !== 64'h12) begin
      failures++; $display("FAIL rst_restart_lane1: idx=%0d lane=%h want 1/12", lane_idx, lane_ops[63:0]);
    end
    repeat (7) @(negedge clk);
    checks++;
    if (out_valid !== 1'b0) begin failures++; $display("FAIL rst_restart_done: valid=%b want 0", out_valid); end
  endtask

  task automatic test_multi_operand();
    logic [NOPS*W-1:0] exp_l [4];
    exp_l[0] = {48'h0, 16'h8001, 48'h0, 16'hCDEF, 48'h0, 16'hDDDD};
    exp_l[1] = {48'h0, 16'h1234, 48'h0, 16'h89AB, 48'h0, 16'hCCCC};
    exp_l[2] = {48'h0, 16'h0FF0, 48'h0, 16'h4567, 48'h0, 16'hBBBB};
    exp_l[3] = {48'h0, 16'hF00F, 48'h0, 16'h0123, 48'h0, 16'hAAAA};
    @(negedge clk);
    in_valid = 1'b1; fmt = FP16; out_ready = 1'b1;
    ops = {64'hF00F_0FF0_1234_8001, 64'h0123_4567_89AB_CDEF, 64'hAAAA_BBBB_CCCC_DDDD};
    @(negedge clk);
    in_valid = 1'b0;
    for (int unsigned i = 0; i < 4; i++) begin
      checks++;
      if (out_valid !== 1'b1 || lane_idx !== 3'(i) || last !== (i == 3) || lane_ops !== exp_l[i]) begin
        failures++; $display("FAIL multi_lane%0d: v=%b idx=%0d last=%b lane=%h want %h", i, out_valid, lane_idx, last, lane_ops, exp_l[i]);
      end
      @(negedge clk);
    end
    checks++;
    if (out_valid !== 1'b0) begin failures++; $display("FAIL multi_done: valid=%b want 0", out_valid); end
  endtask

  initial begin
    checks = 0;
    failures = 0;
    test_reset();
    test_fp32_basic();
    test_fp8_order();
    test_backpressure();
    test_back_to_back();
    test_mid_reset();
    test_multi_operand();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
